// File: rtl/adaptive_thresh_reader.sv
`default_nettype none
// adaptive_thresh_reader: raster-scans the frame SRAM and streams a row-wise moving-average
// binarisation of every pixel through a small credit-controlled output FIFO.
module adaptive_thresh_reader #(
    parameter int IMG_W      = 320,
    parameter int IMG_H      = 240,
    parameter int A_WIDTH    = 17,
    parameter int D_WIDTH    = 8,
    parameter int LOG2_WIN   = 3,
    parameter int OFFSET     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_sram_en,
    output logic               o_sram_rw,
    output logic [A_WIDTH-1:0] o_sram_addr,
    input  logic [D_WIDTH-1:0] i_sram_rd_data,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic               o_out_bin,
    output logic [D_WIDTH-1:0] o_out_pix,
    output logic [8:0]         o_out_x,
    output logic [7:0]         o_out_y,
    output logic               o_out_last
);
    localparam int c_WIN = 1 << LOG2_WIN;
    localparam int c_SW  = D_WIDTH + LOG2_WIN;
    localparam int c_CW  = c_SW + 1;
    localparam int c_PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_NW  = $clog2(FIFO_DEPTH + 1);
    localparam int c_NW1 = c_NW + 1;
    localparam logic [A_WIDTH-1:0] c_LAST_ADDR = A_WIDTH'(IMG_W * IMG_H - 1);
    localparam logic [c_NW:0]      c_LIMIT     = c_NW1'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic               bin;
        logic [D_WIDTH-1:0] pix;
        logic [8:0]         x;
        logic [7:0]         y;
        logic               last;
    } entry_t;

    state_t             r_state, w_state_next;
    logic [A_WIDTH-1:0] r_addr;
    logic [8:0]         r_x, r_rd_x;
    logic [7:0]         r_y, r_rd_y;
    logic               r_inflight, r_rd_last;
    logic [D_WIDTH-1:0] r_hist [c_WIN];
    logic [c_SW-1:0]    r_sum;
    entry_t             r_mem [FIFO_DEPTH];
    logic [c_PW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [c_NW-1:0]    r_count;

    logic               w_sram_en, w_valid, w_push, w_pop, w_bin;
    logic [c_NW:0]      w_credit;
    logic [D_WIDTH-1:0] w_pix, w_oldest;
    logic [c_SW-1:0]    w_sum_next;
    logic [c_CW-1:0]    w_lhs;
    entry_t             w_head;

    function automatic logic [c_PW-1:0] f_next_ptr(input logic [c_PW-1:0] p);
        return (p == c_PW'(FIFO_DEPTH - 1)) ? '0 : p + c_PW'(1);
    endfunction

    // Reads in flight count against FIFO space so data arriving a cycle later always fits.
    assign w_credit  = {1'b0, r_count} + {{c_NW{1'b0}}, r_inflight};
    assign w_sram_en = (r_state == S_RUN) && (w_credit < c_LIMIT);
    assign w_valid   = (r_count != '0);
    assign w_push    = r_inflight;
    assign w_pop     = w_valid & i_out_ready;
    assign w_head    = r_mem[r_rd_ptr];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_next = S_RUN;
            S_RUN:   if (w_sram_en && (r_addr == c_LAST_ADDR)) w_state_next = S_DRAIN;
            S_DRAIN: if (w_pop && w_head.last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr     <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_inflight <= 1'b0;
            r_rd_x     <= '0;
            r_rd_y     <= '0;
            r_rd_last  <= 1'b0;
        end else begin
            r_inflight <= w_sram_en;
            if ((r_state == S_IDLE) && i_start) begin
                r_addr <= '0;
                r_x    <= '0;
                r_y    <= '0;
            end else if (w_sram_en) begin
                r_rd_x    <= r_x;
                r_rd_y    <= r_y;
                r_rd_last <= (r_addr == c_LAST_ADDR);
                r_addr    <= r_addr + A_WIDTH'(1);
                if (r_x == 9'(IMG_W - 1)) begin
                    r_x <= '0;
                    r_y <= r_y + 8'd1;
                end else begin
                    r_x <= r_x + 9'd1;
                end
            end
        end
    end

    // At x==0 the history is prefilled with the new pixel so the window never spans rows.
    assign w_pix      = i_sram_rd_data;
    assign w_oldest   = r_hist[c_WIN-1];
    assign w_sum_next = (r_rd_x == '0) ? (c_SW'(w_pix) << LOG2_WIN)
                                       : (r_sum + c_SW'(w_pix) - c_SW'(w_oldest));
    assign w_lhs      = (c_CW'(w_pix) + c_CW'(OFFSET)) << LOG2_WIN;
    assign w_bin      = (w_lhs > c_CW'(w_sum_next));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sum <= '0;
            for (int i = 0; i < c_WIN; i++) r_hist[i] <= '0;
        end else if (r_inflight) begin
            r_sum     <= w_sum_next;
            r_hist[0] <= w_pix;
            for (int i = 1; i < c_WIN; i++) r_hist[i] <= (r_rd_x == '0) ? w_pix : r_hist[i-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= '{bin: w_bin, pix: w_pix, x: r_rd_x, y: r_rd_y, last: r_rd_last};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= f_next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= f_next_ptr(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_NW'(1);
                2'b01:   r_count <= r_count - c_NW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign o_done      = (r_state == S_DONE);
    assign o_sram_en   = w_sram_en;
    assign o_sram_rw   = 1'b0;
    assign o_sram_addr = r_addr;
    assign o_out_valid = w_valid;
    assign o_out_bin   = w_valid & w_head.bin;
    assign o_out_pix   = w_valid ? w_head.pix : '0;
    assign o_out_x     = w_valid ? w_head.x : '0;
    assign o_out_y     = w_valid ? w_head.y : '0;
    assign o_out_last  = w_valid & w_head.last;
endmodule
`default_nettype wire
